// File: rtl/afifo_pkg.sv
// Shared helpers for the dual-clock FIFO: pointer code conversion and
// synchroniser depth, plus the unpacker state encoding.
package afifo_pkg;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned PTR_MAX_W   = 32;

    typedef enum logic {
        UNP_EMPTY,
        UNP_HOLD
    } unp_state_t;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b = g;
        for (int unsigned s = 1; s < PTR_MAX_W; s = s << 1) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/afifo_unpack_if.sv
// Write-side push bus and read-side slice handshake of afifo_unpack.
interface afifo_unpack_if #(
    parameter int unsigned OUT_W = 200,
    parameter int unsigned RATIO = 2
);
    logic [RATIO*OUT_W-1:0] data_in;
    logic                   write_enable;
    logic                   full;
    logic                   overflow;
    logic [OUT_W-1:0]       data_out;
    logic                   data_out_valid;
    logic                   data_out_ready;
    logic                   data_out_last;

    modport master (
        output data_in, write_enable, data_out_ready,
        input  full, overflow, data_out, data_out_valid, data_out_last
    );

    modport slave (
        input  data_in, write_enable, data_out_ready,
        output full, overflow, data_out, data_out_valid, data_out_last
    );
endinterface

// File: rtl/afifo_core.sv
// Dual-clock first-word-fall-through FIFO with Gray pointers, sticky overflow
// and a write-domain copy of the read-domain reset.
module afifo_core
    import afifo_pkg::*;
#(
    parameter int unsigned W          = 400,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic         write_clk,
    input  logic         read_clk,
    input  logic         rst,
    input  logic [W-1:0] i_wdata,
    input  logic         i_wen,
    output logic         o_full,
    output logic         o_overflow,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_empty
);
    localparam int unsigned PW = DEPTH_LOG2 + 1;
    // Full when the top two Gray bits are inverted and the rest match.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (DEPTH_LOG2 - 1);

    logic [W-1:0]                   r_mem [2**DEPTH_LOG2];
    logic [SYNC_STAGES-1:0]         r_wrst;
    logic [PW-1:0]                  r_wbin, r_wgray, r_rbin, r_rgray;
    logic [SYNC_STAGES-1:0][PW-1:0] r_rq, r_wq;
    logic                           r_overflow;
    logic                           w_wrst, w_push, w_pop;
    logic [PW-1:0]                  w_wbin_nxt, w_rbin_nxt;

    always_ff @(posedge write_clk) begin
        r_wrst <= {r_wrst[SYNC_STAGES-2:0], rst};
    end
    assign w_wrst = r_wrst[SYNC_STAGES-1];

    assign o_full     = w_wrst || (r_wgray == (r_rq[SYNC_STAGES-1] ^ FULL_MASK));
    assign o_overflow = r_overflow;
    assign w_push     = i_wen && !o_full;
    assign w_wbin_nxt = r_wbin + PW'(1);

    always_ff @(posedge write_clk) begin
        if (w_wrst) begin
            r_wbin     <= '0;
            r_wgray    <= '0;
            r_rq       <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_rq <= {r_rq[SYNC_STAGES-2:0], r_rgray};
            if (w_push) begin
                r_wbin  <= w_wbin_nxt;
                r_wgray <= PW'(bin2gray(PTR_MAX_W'(w_wbin_nxt)));
            end
            if (i_wen && o_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge write_clk) begin
        if (w_push) begin
            r_mem[r_wbin[DEPTH_LOG2-1:0]] <= i_wdata;
        end
    end

    assign o_empty    = (r_rgray == r_wq[SYNC_STAGES-1]);
    assign w_pop      = i_pop && !o_empty;
    assign w_rbin_nxt = r_rbin + PW'(1);
    assign o_rdata    = r_mem[r_rbin[DEPTH_LOG2-1:0]];

    always_ff @(posedge read_clk) begin
        if (rst) begin
            r_rbin  <= '0;
            r_rgray <= '0;
            r_wq    <= '0;
        end else begin
            r_wq <= {r_wq[SYNC_STAGES-2:0], r_wgray};
            if (w_pop) begin
                r_rbin  <= w_rbin_nxt;
                r_rgray <= PW'(bin2gray(PTR_MAX_W'(w_rbin_nxt)));
            end
        end
    end

endmodule

// File: rtl/afifo_unpack.sv
// Dual-clock FIFO whose read side emits each wide word as RATIO narrow
// slices, LSB slice first, under a valid/ready handshake.
module afifo_unpack
    import afifo_pkg::*;
#(
    parameter int unsigned OUT_W      = 200,
    parameter int unsigned RATIO      = 2,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic          read_clk,
    input  logic          write_clk,
    input  logic          rst,
    afifo_unpack_if.slave bus
);
    localparam int unsigned IN_W  = RATIO * OUT_W;
    localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    unp_state_t       r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [IN_W-1:0]  r_word, w_fifo_data;
    logic             w_empty, w_pop, w_accept, w_at_last, w_have;

    afifo_core #(
        .W          (IN_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_core (
        .write_clk  (write_clk),
        .read_clk   (read_clk),
        .rst        (rst),
        .i_wdata    (bus.data_in),
        .i_wen      (bus.write_enable),
        .o_full     (bus.full),
        .o_overflow (bus.overflow),
        .i_pop      (w_pop),
        .o_rdata    (w_fifo_data),
        .o_empty    (w_empty)
    );

    assign w_have    = (r_state == UNP_HOLD);
    assign w_at_last = (r_idx == LAST_IDX);
    assign w_accept  = w_have && bus.data_out_ready;
    // Refill on the same edge the last slice leaves, so words stream gap-free.
    assign w_pop     = !w_empty && (!w_have || (w_accept && w_at_last));

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (w_pop) begin
            w_state_nxt = UNP_HOLD;
            w_idx_nxt   = '0;
        end else if (w_accept) begin
            if (w_at_last) begin
                w_state_nxt = UNP_EMPTY;
            end else begin
                w_idx_nxt = r_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge read_clk) begin
        if (rst) begin
            r_state <= UNP_EMPTY;
            r_idx   <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_pop) begin
                r_word <= w_fifo_data;
            end
        end
    end

    assign bus.data_out       = OUT_W'(r_word >> (32'(r_idx) * OUT_W));
    assign bus.data_out_valid = w_have;
    assign bus.data_out_last  = w_have && w_at_last;

endmodule

// File: tb/tb_afifo_unpack.sv
// Scoreboard bench: an 8-bit x4 instance for ordering, backpressure,
// full/overflow, reset and streaming, plus a default-width instance.
module tb_afifo_unpack;

    logic read_clk  = 1'b0;
    logic write_clk = 1'b0;
    logic rst       = 1'b1;

    always #2 read_clk  = ~read_clk;
    always #5 write_clk = ~write_clk;

    afifo_unpack_if #(.OUT_W(8),   .RATIO(4)) ifa ();
    afifo_unpack_if #(.OUT_W(200), .RATIO(2)) ifb ();

    afifo_unpack #(.OUT_W(8), .RATIO(4), .DEPTH_LOG2(4)) dut_a (
        .read_clk  (read_clk),
        .write_clk (write_clk),
        .rst       (rst),
        .bus       (ifa.slave)
    );

    afifo_unpack #(.OUT_W(200), .RATIO(2), .DEPTH_LOG2(4)) dut_b (
        .read_clk  (read_clk),
        .write_clk (write_clk),
        .rst       (rst),
        .bus       (ifb.slave)
    );

    typedef struct packed { logic [7:0]   data; logic last; } exp_a_t;
    typedef struct packed { logic [199:0] data; logic last; } exp_b_t;

    exp_a_t      qa[$];
    exp_b_t      qb[$];
    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned cyc = 0;
    int unsigned wcyc = 0;
    int unsigned gaps = 0;
    int unsigned b_prev = 0;
    bit          streaming = 1'b0;

    always @(posedge read_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [399:0] act, input logic [399:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic unexpected(input string name, input logic [399:0] act);
        n_total++;
        $display("FAIL %s: got slice %0h, expected no output", name, act);
    endtask

    // Monitor A: scoreboard pops, stability under backpressure, gap count.
    logic       pv_valid = 1'b0, pv_ready = 1'b0, pv_last = 1'b0;
    logic [7:0] pv_data  = '0;
    always @(negedge read_clk) begin
        exp_a_t e;
        if (!rst) begin
            if (pv_valid && !pv_ready)
                check("a_hold", {ifa.data_out_valid, ifa.data_out_last, ifa.data_out},
                      {1'b1, pv_last, pv_data});
            if (ifa.data_out_valid && ifa.data_out_ready) begin
                if (qa.size() == 0) unexpected("a_unexpected", ifa.data_out);
                else begin
                    e = qa.pop_front();
                    check("a_slice", {ifa.data_out_last, ifa.data_out}, {e.last, e.data});
                end
            end
            if (streaming && ifa.data_out_ready && !ifa.data_out_valid && qa.size() > 24)
                gaps <= gaps + 1;
        end
        pv_valid <= ifa.data_out_valid;
        pv_ready <= ifa.data_out_ready;
        pv_last  <= ifa.data_out_last;
        pv_data  <= ifa.data_out;
    end

    always @(negedge read_clk) begin
        exp_b_t e;
        if (!rst && ifb.data_out_valid && ifb.data_out_ready) begin
            if (qb.size() == 0) unexpected("b_unexpected", ifb.data_out);
            else begin
                e = qb.pop_front();
                check("b_slice", {ifb.data_out_last, ifb.data_out}, {e.last, e.data});
                if (e.last) check("b_back_to_back", cyc - b_prev, 1);
                b_prev <= cyc;
            end
        end
    end

    task automatic model_a(input logic [31:0] w);
        for (int unsigned k = 0; k < 4; k++)
            qa.push_back('{data: w[8*k +: 8], last: (k == 3)});
    endtask

    task automatic push_a(input logic [31:0] w, input bit model);
        @(negedge write_clk);
        ifa.data_in      = w;
        ifa.write_enable = 1'b1;
        if (model) model_a(w);
        @(posedge write_clk);
        #1 ifa.write_enable = 1'b0;
    endtask

    task automatic push_b(input logic [399:0] w);
        @(negedge write_clk);
        ifb.data_in      = w;
        ifb.write_enable = 1'b1;
        qb.push_back('{data: w[199:0],   last: 1'b0});
        qb.push_back('{data: w[399:200], last: 1'b1});
        @(posedge write_clk);
        wcyc = cyc;
        #1 ifb.write_enable = 1'b0;
    endtask

    task automatic set_ready_a(input logic v);
        @(posedge read_clk);
        #1 ifa.data_out_ready = v;
    endtask

    task automatic wait_valid_a(input string name);
        int unsigned n = 0;
        while (!ifa.data_out_valid && n < 200) begin @(negedge read_clk); n++; end
        check(name, ifa.data_out_valid, 1);
    endtask

    task automatic drain(input string name);
        int unsigned n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 20000) begin @(negedge read_clk); n++; end
        check(name, {qa.size() == 0, qb.size() == 0}, 2'b11);
    endtask

    task automatic wait_not_full(input string name);
        int unsigned n = 0;
        while (ifa.full && n < 50) begin @(negedge write_clk); n++; end
        check(name, ifa.full, 0);
    endtask

    initial begin
        logic [31:0] w;
        int unsigned n;
        ifa.data_in = '0; ifa.write_enable = 1'b0; ifa.data_out_ready = 1'b0;
        ifb.data_in = '0; ifb.write_enable = 1'b0; ifb.data_out_ready = 1'b1;

        repeat (8) @(posedge write_clk);
        @(negedge read_clk);
        check("rst_valid", {ifa.data_out_valid, ifb.data_out_valid}, 0);
        check("rst_data", ifa.data_out, 0);
        check("rst_last", {ifa.data_out_last, ifb.data_out_last}, 0);
        check("rst_full", {ifa.full, ifb.full}, 2'b11);
        check("rst_overflow", {ifa.overflow, ifb.overflow}, 0);
        @(posedge read_clk);
        #1 rst = 1'b0;
        wait_not_full("full_release");

        // Default width: {B,A} -> A then B, valid on 3rd read edge after write.
        push_b({{50{4'hB}}, {50{4'hA}}});
        n = 0;
        while (!ifb.data_out_valid && n < 20) begin @(negedge read_clk); n++; end
        check("b_first_latency", cyc - wcyc, 3);
        drain("b_drain");

        set_ready_a(1'b1);
        qa.push_back('{data: 8'hAA, last: 1'b0});
        qa.push_back('{data: 8'hBB, last: 1'b0});
        qa.push_back('{data: 8'hCC, last: 1'b0});
        qa.push_back('{data: 8'hDD, last: 1'b1});
        push_a(32'hDDCCBBAA, 1'b0);
        drain("order_drain");

        // Backpressure: accept slice 0, then hold slice 1 stalled.
        set_ready_a(1'b0);
        push_a(32'h44332211, 1'b1);
        wait_valid_a("bp_valid");
        check("bp_slice0", ifa.data_out, 8'h11);
        set_ready_a(1'b1);
        set_ready_a(1'b0);
        repeat (5) @(posedge read_clk);
        @(negedge read_clk);
        check("bp_hold", {ifa.data_out_valid, ifa.data_out_last, ifa.data_out}, {1'b1, 1'b0, 8'h22});

        // Unpacker holds a word, so 16 pushes fill the memory exactly.
        for (int unsigned i = 0; i < 16; i++) begin
            push_a({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 1'b1);
            if (i == 14) check("full_at_15", ifa.full, 0);
            if (i == 15) check("full_at_16", ifa.full, 1);
        end
        check("ovf_before", ifa.overflow, 0);
        push_a(32'hEEEEEEEE, 1'b0);
        check("ovf_set", {ifa.full, ifa.overflow}, 2'b11);
        set_ready_a(1'b1);
        drain("full_drain");
        wait_not_full("full_after_drain");
        check("ovf_sticky", ifa.overflow, 1);

        // Reset with slice 1 of the third word pending.
        set_ready_a(1'b0);
        push_a(32'hA3A2A1A0, 1'b1);
        push_a(32'hB3B2B1B0, 1'b1);
        push_a(32'hC3C2C1C0, 1'b1);
        push_a(32'hD3D2D1D0, 1'b0);
        repeat (10) @(posedge read_clk);
        #1 check("mid_slice0", ifa.data_out, 8'hA0);
        set_ready_a(1'b1);
        repeat (9) @(posedge read_clk);
        #1 ifa.data_out_ready = 1'b0;
        check("mid_pending", {ifa.data_out_valid, ifa.data_out}, {1'b1, 8'hC1});
        rst = 1'b1;
        qa.delete();
        @(posedge read_clk);
        @(negedge read_clk);
        check("mid_rst_out", {ifa.data_out_valid, ifa.data_out_last, ifa.data_out}, 0);
        repeat (4) @(posedge write_clk);
        #1 check("mid_rst_wside", {ifa.full, ifa.overflow}, 2'b10);
        @(posedge read_clk);
        #1 rst = 1'b0;
        wait_not_full("mid_release");
        push_a(32'h55555555, 1'b1);
        wait_valid_a("mid_new_valid");
        check("mid_first_after_rst", ifa.data_out, 8'h55);
        set_ready_a(1'b1);
        drain("mid_drain");

        // Streaming: writer respects full, reader always ready.
        streaming = 1'b1;
        n = 0;
        w = $urandom;
        while (n < 1000) begin
            @(negedge write_clk);
            if (!ifa.full) begin
                ifa.data_in      = w;
                ifa.write_enable = 1'b1;
                model_a(w);
                n++;
                w = $urandom;
            end else begin
                ifa.write_enable = 1'b0;
            end
        end
        @(negedge write_clk);
        ifa.write_enable = 1'b0;
        drain("stream_drain");
        streaming = 1'b0;
        check("stream_gaps", gaps, 0);
        check("stream_overflow", ifa.overflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total + 1);
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1);
    end

endmodule
